// File: rtl/serializer_4_to_1_pkg.sv
// serializer_4_to_1_pkg: state encoding and lane-slice helper shared by the serializer and its future deserializer counterpart.
package serializer_4_to_1_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Bit offset of lane k inside a packed word whose lanes are w bits wide.
    function automatic int lane_offset(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/serializer_4_to_1.sv
// serializer_4_to_1: replays one packed N_INPUTS*DATA_WIDTH word as N_INPUTS single-lane beats, lane 0 first.
// Ports: clk/reset (sync, active-high); r/in_valid/in_ready accept a packed word;
//        out_data/out_lane/out_last/out_valid/out_ready stream the beats.
module serializer_4_to_1
    import serializer_4_to_1_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int N_INPUTS   = 4,
    localparam int LANE_W     = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] r,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [LANE_W-1:0]              out_lane,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    ser_state_e                     state_q, state_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [N_INPUTS*DATA_WIDTH-1:0] hold_q, hold_d;
    logic                           last, beat_xfer, in_xfer;

    assign last      = lane_q == LANE_W'(N_INPUTS - 1);
    assign beat_xfer = state_q == SEND && out_ready;
    // Accepting on the last beat lets the next word follow without a bubble.
    assign in_ready  = state_q == IDLE || (beat_xfer && last);
    assign in_xfer   = in_valid && in_ready;

    assign out_valid = state_q == SEND;
    assign out_last  = out_valid && last;
    assign out_lane  = lane_q;
    assign out_data  = out_valid ? hold_q[lane_offset(int'(lane_q), DATA_WIDTH) +: DATA_WIDTH] : '0;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        if (in_xfer) begin
            state_d = SEND;
            lane_d  = '0;
            hold_d  = r;
        end else if (beat_xfer) begin
            state_d = last ? IDLE : SEND;
            lane_d  = last ? '0 : lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_serializer_4_to_1.sv
// tb_serializer_4_to_1: directed stimulus with a queue scoreboard checked by an independent beat monitor.
module tb_serializer_4_to_1;

    logic        clk, reset, in_valid, in_ready, out_last, out_valid, out_ready;
    logic [63:0] r;
    logic [15:0] out_data;
    logic [1:0]  out_lane;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    localparam logic [63:0] WA = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    localparam logic [63:0] WB = {16'h0123, 16'h00BB, 16'h0AAA, 16'hAAAA};

    serializer_4_to_1 dut (
        .clk(clk), .reset(reset), .r(r), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({w[k*16 +: 16], 2'(k), k == 3});
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h lane %0d, expected no beat at %0t", out_data, out_lane, $time);
            end else begin
                check("beat", {13'b0, out_data, out_lane, out_last}, {13'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; in_valid = 0; out_ready = 1; r = '0;
        repeat (2) tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_lane", 32'(out_lane), 0);
        check("rst_last", 32'(out_last), 0);
        reset = 0;
        tick();
        check("idle_in_ready", 32'(in_ready), 1);

        // basic word
        r = WA; in_valid = 1; push_word(WA);
        tick();
        in_valid = 0;
        check("latency_valid", 32'(out_valid), 1);
        repeat (4) tick();
        check("basic_done_valid", 32'(out_valid), 0);

        // backpressure at lane 1
        r = WA; in_valid = 1; push_word(WA);
        tick();
        in_valid = 0;
        tick();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("bp_data", 32'(out_data), 32'h4567);
            check("bp_lane", 32'(out_lane), 1);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1;
        repeat (3) tick();
        check("bp_done_valid", 32'(out_valid), 0);

        // back-to-back words
        r = WA; in_valid = 1; push_word(WA);
        tick();
        r = WB; push_word(WB);
        for (int i = 0; i < 4; i++) begin
            check("b2b_in_ready", 32'(in_ready), 32'(i == 3));
            check("b2b_valid_a", 32'(out_valid), 1);
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid_b", 32'(out_valid), 1);
            tick();
        end
        check("b2b_done_valid", 32'(out_valid), 0);

        // input stability
        r = WA; in_valid = 1; push_word(WA);
        tick();
        in_valid = 0; r = {4{16'hFFFF}};
        repeat (4) tick();
        check("stab_done_valid", 32'(out_valid), 0);

        // reset mid-word
        r = WA; in_valid = 1; push_word(WA);
        tick();
        in_valid = 0;
        repeat (2) tick();
        check("mid_data", 32'(out_data), 32'h89AB);
        reset = 1;
        exp_q.delete();
        tick();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        reset = 0;
        repeat (3) tick();
        check("mid_after_valid", 32'(out_valid), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serializer_4_to_1.md
Name: serializer_4_to_1

Overview:
Downstream consumer of the 4-input packing adapter. Takes the packed N_INPUTS*DATA_WIDTH word (lane 0 in the LSBs) through a valid/ready handshake. Replays it as N_INPUTS consecutive DATA_WIDTH beats, lane 0 first, on a valid/ready stream. Sits between the packing adapter and any narrow single-lane consumer, for example a FIFO or a link transmitter.

Parameters:
DATA_WIDTH, 16, width of one lane and of each output beat.
N_INPUTS, 4, lanes per packed word; must be ≥ 2.
LANE_W, $clog2(N_INPUTS), width of the lane index (localparam, not overridable).

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
r  input  N_INPUTS*DATA_WIDTH  packed word; lane k = r[k*DATA_WIDTH +: DATA_WIDTH].
in_valid  input  1  r holds a word to transfer.
in_ready  output  1  serializer can accept r this cycle.
out_data  output  DATA_WIDTH  current beat.
out_lane  output  LANE_W  lane index of out_data.
out_last  output  1  high on the lane N_INPUTS-1 beat.
out_valid  output  1  out_data/out_lane/out_last are valid.
out_ready  input  1  downstream accepts the beat this cycle.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, holding register=0, lane counter=0.
  - out_valid=0, out_data=0, out_lane=0, out_last=0.
  - in_ready=1 in the cycle after reset deasserts.
- Reset mid-word: the partially sent word is discarded and no further beats of it are emitted.
- Handshake rules:
  - Input transfer occurs on an edge where in_valid && in_ready.
  - An output beat transfers on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_lane and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- States:
  - IDLE: out_valid=0; in_ready=1. On an input transfer, latch r, set lane=0 and go to SEND.
  - SEND: out_valid=1; out_data = lane `lane` of the holding register; out_last = (lane==N_INPUTS-1).
    - Beat transfer with lane<N_INPUTS-1: lane increments.
    - Beat transfer on the last lane with in_valid=1: latch the new r, lane=0, stay in SEND. No bubble.
    - Beat transfer on the last lane with in_valid=0: go to IDLE.
- in_ready = (state==IDLE) || (state==SEND && out_last && out_ready). This is combinational from out_ready; no path from in_valid.
- Latency: first beat is valid the cycle after the input transfer.
- Throughput: one beat per cycle when out_ready=1; back-to-back words give N_INPUTS*k beats in N_INPUTS*k cycles.
- r is sampled only at the transfer edge; changes on r afterwards do not affect the word in flight.
- Widths: the lane counter wraps from N_INPUTS-1 to 0 only via reload. No arithmetic on data; bits pass through unchanged.

Decomposition:
- Shared package/include: state encoding localparams (IDLE=0, SEND=1) and the lane-slice helper (index k -> bit offset k*DATA_WIDTH). Both are reused by the packing adapter's future deserializer counterpart.
- No sub-module needed. A single always block for state/counter/holding register plus combinational output selection.
- The gate-level twin is named serializer_4_to_1Synth for equivalence runs.

Test Plan:
- Basic word:
  - Stimulus: r={16'hCDEF,16'h89AB,16'h4567,16'h0123}, in_valid pulse, out_ready=1.
  - Required response: beats 0123,4567,89AB,CDEF on 4 consecutive cycles starting 1 cycle after acceptance; out_lane 0..3; out_last only on CDEF; then out_valid=0.
- Backpressure:
  - Stimulus: same word, out_ready=0 for 3 cycles at lane 1.
  - Required response: out_data stays 4567, out_lane stays 1, out_valid stays 1; in_ready=0 throughout; sequence resumes with 89AB.
- Back-to-back words:
  - Stimulus: word A={CDEF,89AB,4567,0123}, then in_valid held with B={0123,00BB,0AAA,AAAA}.
  - Required response: in_ready=1 only on A's last beat; 8 beats in 8 cycles ending AAAA,0AAA,00BB,0123; no gap.
- Reset mid-word:
  - Stimulus: assert reset after beat 89AB was presented.
  - Required response: next cycle out_valid=0, out_data=0, in_ready=1; CDEF is never emitted.
- Input stability:
  - Stimulus: change r to 16'hFFFF in all lanes after acceptance.
  - Required response: emitted beats still match the latched word.
- Equivalence:
  - Stimulus: all of the above run against serializer_4_to_1Synth.
  - Required response: identical outputs every cycle; the bench asserts equality.
